// File: rtl/fifo_burst_pkg.sv
// Shared types and constants for the FIFO burst reader.
package fifo_burst_pkg;

  // Controller states; encodings are fixed so they read the same in waveforms across blocks.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StBurst = 2'd2
  } state_e;

  // Entries in the output skid buffer.
  localparam int unsigned BufDepth = 2;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry valid/ready output buffer. The head entry drives the stream; the tail entry
// absorbs one extra word so pops can continue for a cycle under backpressure.
module stream_buf2
  import fifo_burst_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [1:0]            buf_cnt
);

  logic [DATA_WIDTH-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic                  head_last_q, head_last_d, tail_last_q, tail_last_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  pop;

  assign pop     = m_valid && m_ready;
  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = head_data_q;
  assign m_last  = head_last_q;
  assign buf_cnt = cnt_q;

  // Next-state for the two entries and occupancy.
  always_comb begin
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    cnt_d       = cnt_q;
    if (cnt_q == 2'd0) begin
      if (push) begin
        head_data_d = push_data;
        head_last_d = push_last;
        cnt_d       = 2'd1;
      end
    end else if (cnt_q == 2'd1) begin
      if (push && pop) begin
        head_data_d = push_data;
        head_last_d = push_last;
      end else if (push) begin
        tail_data_d = push_data;
        tail_last_d = push_last;
        cnt_d       = 2'(BufDepth);
      end else if (pop) begin
        cnt_d = 2'd0;
      end
    end else if (pop) begin
      // Full: tail moves up; a concurrent push refills the tail.
      head_data_d = tail_data_q;
      head_last_d = tail_last_q;
      if (push) begin
        tail_data_d = push_data;
        tail_last_d = push_last;
      end else begin
        cnt_d = 2'd1;
      end
    end
  end

  // Buffer storage with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_last_q <= tail_last_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller: drains a show-ahead FIFO into a valid/ready stream in bursts
// started by occupancy, by a WAIT timeout, or by a flush pulse.
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  output logic                  fifo_rd_req,
  input  logic                  fifo_rd_empty,
  input  logic [ADDR_WIDTH:0]   fifo_num,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int unsigned         TmoW      = $clog2(TIMEOUT) + 1;
  localparam logic [ADDR_WIDTH:0] BurstLenW = (ADDR_WIDTH + 1)'(BURST_LEN);
  localparam logic [TmoW-1:0]     TmoLast   = TmoW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ADDR_WIDTH:0] beats_q, beats_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [1:0]          buf_cnt;
  logic                last_word;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      beats_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      tmo_q   <= tmo_d;
    end
  end

  // Burst start decisions, timeout counting and beat countdown.
  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (flush && (fifo_num != '0)) begin
          state_d = StBurst;
          beats_d = fifo_num;
        end else if (enable && (fifo_num >= BurstLenW)) begin
          state_d = StBurst;
          beats_d = BurstLenW;
        end else if (enable && (fifo_num != '0)) begin
          state_d = StWait;
          tmo_d   = '0;
        end
      end
      StWait: begin
        if (fifo_num >= BurstLenW) begin
          state_d = StBurst;
          beats_d = BurstLenW;
        end else if (flush) begin
          state_d = StBurst;
          beats_d = fifo_num;
        end else if (tmo_q == TmoLast) begin
          state_d = StBurst;
          beats_d = (fifo_num > BurstLenW) ? BurstLenW : fifo_num;
        end else if (!enable) begin
          state_d = StIdle;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StBurst: begin
        if (fifo_rd_req) begin
          beats_d = beats_q - (ADDR_WIDTH + 1)'(1);
        end
        // Leave one edge after the final pop has been stored.
        if (beats_q == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pop strobe, last-word tag and busy flag; no path from m_ready.
  always_comb begin
    fifo_rd_req = (state_q == StBurst) && !fifo_rd_empty && (buf_cnt < 2'(BufDepth)) &&
                  (beats_q != '0);
    last_word   = fifo_rd_req && (beats_q == (ADDR_WIDTH + 1)'(1));
    busy        = (state_q != StIdle) || (buf_cnt != 2'd0);
  end

  stream_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_rd_req),
    .push_data (fifo_q),
    .push_last (last_word),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .buf_cnt   (buf_cnt)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a behavioural show-ahead FIFO feeds the DUT; a scoreboard of
// pushed words plus a burst-length counter predicts every accepted word and its last flag.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst, enable, flush, m_ready;
  logic       fifo_rd_req, fifo_rd_empty, m_valid, m_last, busy;
  logic [4:0] fifo_num;
  logic [7:0] fifo_q, m_data;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (8),
    .BURST_LEN  (4),
    .TIMEOUT    (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .flush         (flush),
    .fifo_rd_req   (fifo_rd_req),
    .fifo_rd_empty (fifo_rd_empty),
    .fifo_num      (fifo_num),
    .fifo_q        (fifo_q),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .busy          (busy)
  );

  // Behavioural show-ahead FIFO; 'hide' makes it look empty to model late-arriving data.
  logic [7:0] fmem [16];
  logic [3:0] frd = '0, fwr = '0;
  logic [4:0] fcnt = '0;
  logic       wr_en, hide;
  logic [7:0] wr_data;
  logic       fpop;

  assign fifo_rd_empty = (fcnt == 5'd0) || hide;
  assign fifo_num      = fcnt;
  assign fifo_q        = fmem[frd];
  assign fpop          = fifo_rd_req && !fifo_rd_empty;

  always @(posedge clk) begin
    if (fpop) frd <= frd + 4'd1;
    if (wr_en) begin
      fmem[fwr] <= wr_data;
      fwr       <= fwr + 4'd1;
    end
    fcnt <= fcnt + 5'(wr_en) - 5'(fpop);
  end

  // Scoreboard and bookkeeping.
  int         n_tests = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  int         burst_left, burst_reload;
  int         popped = 0, accepted = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data;
  logic       prev_last;
  bit         cyc_pop, cyc_hs, cyc_valid, cyc_last, cyc_busy;

  typedef struct {
    int n;
    bit en;
    bit fl;
    int lat;
    int len;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic observe();
    logic [7:0] ed;
    cyc_pop   = fpop;
    cyc_hs    = m_valid && m_ready;
    cyc_valid = m_valid;
    cyc_last  = m_last;
    cyc_busy  = busy;
    if (prev_stall) begin
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", 32'(m_data), 32'(prev_data));
      check("hold_last", 32'(m_last), 32'(prev_last));
    end
    if (cyc_pop) check("pop_room", 32'((popped - accepted) < 2), 32'd1);
    if (cyc_hs) begin
      if (exp_q.size() == 0) begin
        check("extra_word", 32'(m_data), 32'hffff_ffff);
      end else begin
        ed = exp_q.pop_front();
        check("data", 32'(m_data), 32'(ed));
        check("last", 32'(m_last), 32'(burst_left == 1));
      end
      burst_left--;
      if (burst_left <= 0) burst_left = burst_reload;
      accepted++;
    end
    if (cyc_pop) popped++;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
  endtask

  task automatic tick();
    #1;
    observe();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    m_ready = 1'b1;
    while ((fcnt != 0 || exp_q.size() != 0 || busy) && guard < 300) begin
      tick();
      guard++;
    end
    if (guard >= 300) check({name, "_drain_timeout"}, 32'd1, 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic pulse_flush(input int len);
    burst_left   = len;
    burst_reload = len;
    flush        = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int first_rd, first_v, last_k, nacc, p0, grp;
    bit any_act;
    rst = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
    wr_en = 1'b0; wr_data = '0; hide = 1'b0;

    // Reset values.
    @(negedge clk);
    #1;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_rdreq", 32'(fifo_rd_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // {words preloaded, enable, flush, cycles to first pop (0 = none), first burst length}
    tbl[0] = '{4, 1'b1, 1'b0, 1, 4};   // full burst
    tbl[1] = '{2, 1'b1, 1'b0, 17, 2};  // timeout after 16 WAIT cycles
    tbl[2] = '{3, 1'b0, 1'b1, 1, 3};   // flush
    tbl[3] = '{5, 1'b0, 1'b1, 1, 5};   // flush is not capped at BURST_LEN
    tbl[4] = '{1, 1'b1, 1'b0, 17, 1};  // single-word timeout burst
    tbl[5] = '{3, 1'b1, 1'b1, 1, 3};   // flush wins over enable
    tbl[6] = '{0, 1'b0, 1'b1, 0, 0};   // flush on empty FIFO: nothing
    tbl[7] = '{3, 1'b0, 1'b0, 0, 0};   // disabled: nothing
    tbl[8] = '{8, 1'b1, 1'b0, 1, 4};   // two back-to-back full bursts

    for (int r = 0; r < 9; r++) begin
      enable  = 1'b0;
      flush   = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < tbl[r].n; i++) push_word(8'((r << 4) | i));
      burst_left   = tbl[r].len;
      burst_reload = tbl[r].len;
      enable       = tbl[r].en;
      flush        = tbl[r].fl;
      first_rd = -1; first_v = -1; last_k = -1; nacc = 0; any_act = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        flush = 1'b0;
        if (cyc_pop && first_rd < 0) first_rd = k;
        if (cyc_valid && first_v < 0) first_v = k;
        if (cyc_hs) nacc++;
        if (cyc_pop || cyc_valid || cyc_busy) any_act = 1;
        if (cyc_hs && cyc_last) begin
          last_k = k;
          break;
        end
      end
      if (tbl[r].lat > 0) begin
        check($sformatf("row%0d_first_pop", r), 32'(first_rd), 32'(tbl[r].lat));
        check($sformatf("row%0d_first_valid", r), 32'(first_v), 32'(tbl[r].lat + 1));
        check($sformatf("row%0d_burst_len", r), 32'(nacc), 32'(tbl[r].len));
        check($sformatf("row%0d_last_cycle", r), 32'(last_k), 32'(tbl[r].lat + tbl[r].len));
      end else begin
        check($sformatf("row%0d_no_activity", r), 32'(any_act), 32'd0);
        if (tbl[r].n > 0) pulse_flush(tbl[r].n);
      end
      drain($sformatf("row%0d", r));
      enable = 1'b0;
    end

    // Backpressure: consumer stalls for 5 cycles right at burst start.
    for (int i = 0; i < 4; i++) push_word(8'hB0 + 8'(i));
    burst_left = 4; burst_reload = 4;
    m_ready = 1'b0;
    enable  = 1'b1;
    p0 = popped;
    repeat (5) tick();
    check("bp_pops", 32'(popped - p0), 32'd2);
    #1;
    check("bp_rdreq", 32'(fifo_rd_req), 32'd0);
    @(negedge clk);
    enable = 1'b0;
    drain("bp");

    // Empty stall: FIFO reports empty after two pops, burst waits, then completes.
    for (int i = 0; i < 4; i++) push_word(8'hC0 + 8'(i));
    burst_left = 4; burst_reload = 4;
    m_ready = 1'b1;
    enable  = 1'b1;
    p0 = popped;
    for (int g = 0; g < 10 && (popped - p0) < 2; g++) tick();
    hide = 1'b1;
    repeat (6) tick();
    check("stall_pops", 32'(popped - p0), 32'd2);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_valid", 32'(m_valid), 32'd0);
    hide = 1'b0;
    drain("stall");
    check("stall_total", 32'(popped - p0), 32'd4);
    enable = 1'b0;

    // Reset mid-burst: two words sit in the output buffer and are lost.
    for (int i = 0; i < 4; i++) push_word(8'hD0 + 8'(i));
    m_ready = 1'b0;
    pulse_flush(4);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("mrst_valid", 32'(m_valid), 32'd0);
    check("mrst_data", 32'(m_data), 32'd0);
    check("mrst_last", 32'(m_last), 32'd0);
    check("mrst_rdreq", 32'(fifo_rd_req), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    repeat (popped - accepted) void'(exp_q.pop_front());
    popped     = accepted;
    prev_stall = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_post_busy", 32'(busy), 32'd0);
    check("mrst_post_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    m_ready = 1'b1;
    pulse_flush(2);
    drain("mrst");

    // Random traffic: groups of BURST_LEN words, random backpressure, enable held high.
    burst_left = 4; burst_reload = 4;
    enable = 1'b1;
    grp = 0;
    for (int c = 0; c < 800 || grp > 0; c++) begin
      m_ready = ($urandom_range(0, 9) < 7);
      if (grp == 0 && c < 800 && fcnt <= 12 && $urandom_range(0, 3) == 0) grp = 4;
      if (grp > 0) begin
        wr_en   = 1'b1;
        wr_data = 8'($urandom);
        exp_q.push_back(wr_data);
        grp--;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    drain("rand");
    check("rand_all_accepted", 32'(popped - accepted), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
